spi_flash_responder: RTL and testbench
======================================

Name: spi_flash_responder

Overview:
- SPI mode-0 target that emulates the serial NOR flash seen by the flash-loader FSM, so the boot/copy path (flash -> RAMIO -> PSRAM) can run in simulation and on hardware without a real flash.
- Oversamples the controller's flash_clk, flash_mosi and flash_cs in the system clock domain.
- Decodes the READ (0x03) and JEDEC-ID (0x9F) commands.
- Serves read data from an external byte-wide memory port (BRAM/ROM image) on flash_miso.

Parameters:
- MEM_ADDR_BITWIDTH, 21, width of mem_addr; the low bits of the 24-bit flash address.
- JEDEC_ID, 24'hEF4016, 3 bytes returned MSB-first for command 0x9F.

Ports:
- clk  in  1  system clock; must be >= 12x the SCK frequency (each SCK phase >= 6 clk).
- rst  in  1  asynchronous, active-high reset.
- flash_clk  in  1  SCK from the controller, idle low.
- flash_mosi  in  1  controller data, sampled on SCK rising edge.
- flash_cs  in  1  chip select, active low.
- flash_miso  out  1  responder data, changes on SCK falling edge.
- mem_rd_en  out  1  one-cycle read strobe.
- mem_addr  out  MEN_ADDR_BITWIDTH  byte address, valid with mem_rd_en.
- mem_data  in  8  byte, valid exactly 1 clk after mem_rd_en (fixed latency).
- active  out  1  high while a transaction is selected (CS low, synchronized).
- bytes_served  out  32  count of data bytes fully shifted out since reset; wraps.

Behaviour:
- Reset values: flash_miso=0, mem_rd_en=0, mem_addr=0, active=0, bytes_served=0, state=IDLE.
- Input sync: SCK, MOSI and CS each pass through 2 flops. Edges are detected against a third delayed copy. Pin-to-event latency is 3 clk.
- SCK rise event: shift the synchronized MOSI into rx_shift and increment bit_cnt.
- SCK fall event: update flash_miso. The pin changes 1 clk after the event.
- IDLE: flash_miso=0. On CS fall: active<=1, bit_cnt<=0, go to CMD.
- CMD: after the 8th rising edge, compare rx_shift.
  - 0x03: go to ADDR.
  - 0x9F: load tx_shift<=JEDEC_ID[23:16], id_idx<=1, go to ID.
  - Any other value: go to IGNORE.
- ADDR: collect 24 bits MSB-first. On the 24th rising edge:
  - addr<=rx value;
  - mem_rd_en=1 for 1 clk with mem_addr=addr[MEM_ADDR_BITWIDTH-1:0];
  - capture mem_data into next_byte on the following clk;
  - go to DATA with bit_cnt=0.
- DATA: on each SCK fall with bit_cnt==0 (byte boundary):
  - tx_shift<=next_byte, flash_miso<=next_byte[7];
  - addr<=addr+1, 24-bit wrap: 0xFFFFFF -> 0x000000;
  - issue mem_rd_en for the new addr (prefetch);
  - increment bytes_served, except on the first byte of the transaction.
- DATA, other falls: flash_miso<=next tx_shift bit.
- DATA, rising edges: increment bit_cnt mod 8. MOSI is ignored.
- bytes_served rule: it increments on each byte boundary after the first, i.e. when a byte completes its 8th rising edge. The increment is taken at the next fall, or at CS rise if the 8th rising edge has already occurred.
- ID: shift out the 3 JEDEC bytes MSB-first, using the same fall-edge timing as DATA. After the 3rd byte, drive 0x00 for any further bytes. No memory access.
- IGNORE: flash_miso=0, no mem_rd_en, until CS rise.
- CS rise in any state, including mid-byte: next clk gives state=IDLE, active=0, flash_miso=0.
  - A partial byte is not counted.
  - A pending prefetch result is discarded.
- A CS fall in the same clk as an SCK edge event: CS takes priority and the SCK edge is ignored.
- Asynchronous rst asserted mid-transaction: all state and outputs return to their reset values immediately. After release, the block waits in IDLE for a fresh CS fall; a CS already low at release is not treated as a new transaction.
- At most one mem_rd_en per byte; never two in consecutive clks.

Test Plan:
- Mem image byte[i]=i[7:0]. CS low, send 0x03 + 0x000000, clock 32 bits -> miso yields 00 01 02 03; mem_rd_en pulses for addr 0..4; bytes_served=4 after CS rise.
- Send 0x03 + 0xFFFFFE, read 3 bytes with image byte[0x1FFFFE]=0xAA, byte[0x1FFFFF]=0xBB, byte[0]=0xCC -> AA BB CC; mem_addr wraps to 0.
- Send 0x9F, read 4 bytes -> EF 40 16 00; mem_rd_en never asserted.
- Send 0x0B + 4 bytes -> miso constantly 0, no mem_rd_en, bytes_served unchanged.
- 0x03 + 0x000010 with CS raised after 5 bits of the 2nd byte, then a new 0x03 + 0x000020 -> bytes_served increments by 1 for the first transaction; the new read returns byte[0x20] first.
- Assert rst during DATA -> flash_miso=0, active=0, bytes_served=0 in the same cycle; the next transaction (0x03 + 0x000000) reads 00 01 correctly.

Source files
------------

// File: rtl/spi_flash_responder.sv
`default_nettype none
// ============================================================================
// Module   : spi_flash_responder
// Purpose  : SPI mode-0 target that stands in for the serial NOR flash read
//            by the flash-loader. It oversamples SCK/MOSI/CS in the clk
//            domain. It decodes READ (0x03) and JEDEC-ID (0x9F) and serves
//            read data from an external byte-wide memory with a fixed
//            1-clk read latency.
// Ports    : clk, rst            - system clock, async active-high reset
//            flash_clk/mosi/cs   - SPI controller pins (SCK idle low, CS low)
//            flash_miso          - responder data, updated after SCK falls
//            mem_rd_en/mem_addr  - one-cycle read strobe and byte address
//            mem_data            - read byte, valid 1 clk after mem_rd_en
//            active              - transaction selected (synchronized CS low)
//            bytes_served        - completed READ data bytes since reset
// Revision : 1.0 - initial release
// ============================================================================
module spi_flash_responder #(
    parameter int unsigned MEM_ADDR_BITWIDTH = 21,
    parameter logic [23:0] JEDEC_ID          = 24'hEF4016
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flash_clk,
    input  logic                         flash_mosi,
    input  logic                         flash_cs,
    output logic                         flash_miso,
    output logic                         mem_rd_en,
    output logic [MEM_ADDR_BITWIDTH-1:0] mem_addr,
    input  logic [7:0]                   mem_data,
    output logic                         active,
    output logic [31:0]                  bytes_served
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_CMD    = 3'd1;
    localparam logic [2:0] c_ST_ADDR   = 3'd2;
    localparam logic [2:0] c_ST_DATA   = 3'd3;
    localparam logic [2:0] c_ST_ID     = 3'd4;
    localparam logic [2:0] c_ST_IGNORE = 3'd5;

    localparam logic [7:0] c_CMD_READ  = 8'h03;
    localparam logic [7:0] c_CMD_JEDEC = 8'h9F;

    // ------------------------------------------------------------------
    // Pin synchronizers: bit[1] is the synchronized level, bit[2] the
    // delayed copy used for edge detection.
    // ------------------------------------------------------------------
    logic [2:0] sck_sync_q,  sck_sync_d;
    logic [2:0] mosi_sync_q, mosi_sync_d;
    logic [2:0] cs_sync_q,   cs_sync_d;

    // Transaction state
    logic [2:0]                   state_q,     state_d;
    logic [4:0]                   bit_cnt_q,   bit_cnt_d;
    logic [22:0]                  rx_shift_q,  rx_shift_d;
    logic [7:0]                   tx_shift_q,  tx_shift_d;
    logic [23:0]                  addr_q,      addr_d;
    logic [7:0]                   next_byte_q, next_byte_d;
    logic [1:0]                   id_idx_q,    id_idx_d;
    logic                         byte_done_q, byte_done_d;
    logic                         cap_pend_q,  cap_pend_d;
    logic                         miso_q,      miso_d;
    logic                         rd_en_q,     rd_en_d;
    logic [MEM_ADDR_BITWIDTH-1:0] mem_addr_q,  mem_addr_d;
    logic                         active_q,    active_d;
    logic [31:0]                  bytes_q,     bytes_d;

    logic        w_sck_rise;
    logic        w_sck_fall;
    logic        w_cs_fall;
    logic        w_cs_rise;
    logic        w_mosi;
    logic [7:0]  w_rx_byte;
    logic [23:0] w_rx_addr;
    logic [23:0] w_addr_inc;
    logic [7:0]  w_id_byte;
    logic [7:0]  w_out_byte;

    assign w_sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
    assign w_sck_fall = ~sck_sync_q[1] & sck_sync_q[2];
    assign w_cs_fall  = ~cs_sync_q[1] & cs_sync_q[2];
    assign w_cs_rise  = cs_sync_q[1] & ~cs_sync_q[2];
    assign w_mosi     = mosi_sync_q[1];

    // Value of the shift register including the bit arriving on this rise
    assign w_rx_byte  = {rx_shift_q[6:0], w_mosi};
    assign w_rx_addr  = {rx_shift_q, w_mosi};
    assign w_addr_inc = addr_q + 24'd1;   // natural 24-bit wrap

    // JEDEC bytes MSB-first; anything past the third byte reads as zero
    always_comb begin
        w_id_byte = 8'h00;
        case (id_idx_q)
            2'd0:    w_id_byte = JEDEC_ID[23:16];
            2'd1:    w_id_byte = JEDEC_ID[15:8];
            2'd2:    w_id_byte = JEDEC_ID[7:0];
            default: w_id_byte = 8'h00;
        endcase
    end

    assign w_out_byte = (state_q == c_ST_DATA) ? next_byte_q : w_id_byte;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        sck_sync_d  = {sck_sync_q[1:0],  flash_clk};
        mosi_sync_d = {mosi_sync_q[1:0], flash_mosi};
        cs_sync_d   = {cs_sync_q[1:0],   flash_cs};

        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        addr_d      = addr_q;
        id_idx_d    = id_idx_q;
        byte_done_d = byte_done_q;
        miso_d      = miso_q;
        rd_en_d     = 1'b0;
        mem_addr_d  = mem_addr_q;
        active_d    = active_q;
        bytes_d     = bytes_q;

        // Read data arrives the cycle after the strobe; latch it one
        // cycle later into the prefetch buffer.
        cap_pend_d  = rd_en_q;
        next_byte_d = cap_pend_q ? mem_data : next_byte_q;

        if (w_cs_fall) begin
            // CS fall wins over any SCK event seen in the same cycle
            state_d     = c_ST_CMD;
            active_d    = 1'b1;
            bit_cnt_d   = 5'd0;
            byte_done_d = 1'b0;
            miso_d      = 1'b0;
        end else if (w_cs_rise) begin
            // A byte whose 8th rise happened but whose following fall
            // never came (SCK and CS released together) still counts.
            if (state_q == c_ST_DATA && byte_done_q) begin
                bytes_d = bytes_q + 32'd1;
            end
            state_d     = c_ST_IDLE;
            active_d    = 1'b0;
            miso_d      = 1'b0;
            byte_done_d = 1'b0;
            cap_pend_d  = 1'b0;   // drop any in-flight prefetch
        end else begin
            case (state_q)
                c_ST_IDLE: begin
                    miso_d = 1'b0;
                end

                c_ST_CMD: begin
                    if (w_sck_rise) begin
                        rx_shift_d = {rx_shift_q[21:0], w_mosi};
                        bit_cnt_d  = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d = 5'd0;
                            if (w_rx_byte == c_CMD_READ) begin
                                state_d = c_ST_ADDR;
                            end else if (w_rx_byte == c_CMD_JEDEC) begin
                                state_d  = c_ST_ID;
                                id_idx_d = 2'd0;
                            end else begin
                                state_d = c_ST_IGNORE;
                            end
                        end
                    end
                end

                c_ST_ADDR: begin
                    if (w_sck_rise) begin
                        rx_shift_d = {rx_shift_q[21:0], w_mosi};
                        bit_cnt_d  = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd23) begin
                            addr_d      = w_rx_addr;
                            rd_en_d     = 1'b1;
                            mem_addr_d  = w_rx_addr[MEM_ADDR_BITWIDTH-1:0];
                            bit_cnt_d   = 5'd0;
                            byte_done_d = 1'b0;
                            state_d     = c_ST_DATA;
                        end
                    end
                end

                c_ST_DATA, c_ST_ID: begin
                    if (w_sck_rise) begin
                        // MOSI is don't-care here; only the bit position moves
                        bit_cnt_d = {2'b00, bit_cnt_q[2:0] + 3'd1};
                        if (bit_cnt_q[2:0] == 3'd7) begin
                            byte_done_d = 1'b1;
                        end
                    end else if (w_sck_fall) begin
                        if (bit_cnt_q == 5'd0) begin
                            // Byte boundary: present the next byte's MSB
                            miso_d     = w_out_byte[7];
                            tx_shift_d = {w_out_byte[6:0], 1'b0};
                            if (state_q == c_ST_DATA) begin
                                addr_d     = w_addr_inc;
                                rd_en_d    = 1'b1;
                                mem_addr_d = w_addr_inc[MEM_ADDR_BITWIDTH-1:0];
                                if (byte_done_q) begin
                                    bytes_d = bytes_q + 32'd1;
                                end
                            end else if (id_idx_q != 2'd3) begin
                                id_idx_d = id_idx_q + 2'd1;
                            end
                            byte_done_d = 1'b0;
                        end else begin
                            miso_d     = tx_shift_q[7];
                            tx_shift_d = {tx_shift_q[6:0], 1'b0};
                        end
                    end
                end

                c_ST_IGNORE: begin
                    miso_d = 1'b0;
                end

                default: begin
                    state_d = c_ST_IDLE;
                    miso_d  = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers. CS synchronizer resets to "low" so that a CS already
    // asserted when reset is released does not look like a fresh fall.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync_q  <= 3'b000;
            mosi_sync_q <= 3'b000;
            cs_sync_q   <= 3'b000;
            state_q     <= c_ST_IDLE;
            bit_cnt_q   <= 5'd0;
            rx_shift_q  <= 23'd0;
            tx_shift_q  <= 8'd0;
            addr_q      <= 24'd0;
            next_byte_q <= 8'd0;
            id_idx_q    <= 2'd0;
            byte_done_q <= 1'b0;
            cap_pend_q  <= 1'b0;
            miso_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            mem_addr_q  <= '0;
            active_q    <= 1'b0;
            bytes_q     <= 32'd0;
        end else begin
            sck_sync_q  <= sck_sync_d;
            mosi_sync_q <= mosi_sync_d;
            cs_sync_q   <= cs_sync_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            addr_q      <= addr_d;
            next_byte_q <= next_byte_d;
            id_idx_q    <= id_idx_d;
            byte_done_q <= byte_done_d;
            cap_pend_q  <= cap_pend_d;
            miso_q      <= miso_d;
            rd_en_q     <= rd_en_d;
            mem_addr_q  <= mem_addr_d;
            active_q    <= active_d;
            bytes_q     <= bytes_d;
        end
    end

    assign flash_miso   = miso_q;
    assign mem_rd_en    = rd_en_q;
    assign mem_addr     = mem_addr_q;
    assign active       = active_q;
    assign bytes_served = bytes_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_flash_responder
// Purpose  : Self-checking bench for spi_flash_responder. Drives SPI mode-0
//            transactions (directed and $urandom-generated) and compares
//            MISO bytes, memory read addresses and bytes_served against an
//            arithmetic model of the flash behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_flash_responder;

    localparam int          c_HALF = 8;            // clk cycles per SCK phase
    localparam int          c_AW   = 21;
    localparam logic [23:0] c_JEDEC = 24'hEF4016;

    localparam int c_K_READ  = 0;
    localparam int c_K_ID    = 1;
    localparam int c_K_OTHER = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              flash_clk;
    logic              flash_mosi;
    logic              flash_cs;
    logic              flash_miso;
    logic              mem_rd_en;
    logic [c_AW-1:0]   mem_addr;
    logic [7:0]        mem_data;
    logic              active;
    logic [31:0]       bytes_served;

    int                n_chk = 0;
    int                n_fail = 0;
    int                consec_err = 0;
    logic              prev_rd = 1'b0;
    logic [c_AW-1:0]   rd_q[$];
    logic              rx_q[$];
    bit                patch_on = 1'b0;
    logic [31:0]       bs_model = 32'd0;

    always #5 clk = ~clk;

    spi_flash_responder #(
        .MEM_ADDR_BITWIDTH (c_AW),
        .JEDEC_ID          (c_JEDEC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flash_clk    (flash_clk),
        .flash_mosi   (flash_mosi),
        .flash_cs     (flash_cs),
        .flash_miso   (flash_miso),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .active       (active),
        .bytes_served (bytes_served)
    );

    // Memory image: byte[i] = i[7:0], with optional patched bytes
    function automatic logic [7:0] mem_byte(input logic [c_AW-1:0] a);
        if (patch_on && a == 21'h1FFFFE) return 8'hAA;
        if (patch_on && a == 21'h1FFFFF) return 8'hBB;
        if (patch_on && a == 21'h000000) return 8'hCC;
        return a[7:0];
    endfunction

    // Fixed-latency memory: data valid only in the cycle after the strobe
    always @(posedge clk) begin
        if (mem_rd_en) mem_data <= mem_byte(mem_addr);
        else           mem_data <= 8'($urandom);
    end

    // Read-strobe monitor
    always @(negedge clk) begin
        prev_rd <= mem_rd_en;
        if (mem_rd_en) begin
            rd_q.push_back(mem_addr);
            if (prev_rd) consec_err <= consec_err + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic spi_bit(input logic b, input bit last, input bit keep);
        flash_mosi = b;
        repeat (c_HALF) @(negedge clk);
        if (keep) rx_q.push_back(flash_miso);
        flash_clk = 1'b1;
        repeat (c_HALF) @(negedge clk);
        flash_clk = 1'b0;
        if (last) flash_cs = 1'b1;   // CS released together with final fall
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) spi_bit(v[i], 1'b0, 1'b0);
    endtask

    // Expected byte j of the data phase, from the flash's command semantics
    function automatic logic [7:0] exp_byte(input int kind, input logic [23:0] s, input int j);
        logic [23:0] a;
        a = s + 24'(j);
        if (kind == c_K_READ) return mem_byte(a[c_AW-1:0]);
        if (kind == c_K_ID) begin
            if (j == 0) return c_JEDEC[23:16];
            if (j == 1) return c_JEDEC[15:8];
            if (j == 2) return c_JEDEC[7:0];
        end
        return 8'h00;
    endfunction

    task automatic run_txn(input string tag, input int kind, input logic [7:0] cmd,
                           input logic [23:0] s, input int nbits);
        int          rd_base;
        int          nrd;
        int          nb;
        logic [7:0]  got;
        logic [7:0]  exp;
        logic [23:0] ea;
        rd_base = rd_q.size();
        rx_q.delete();
        flash_cs = 1'b0;
        repeat (c_HALF) @(negedge clk);
        check_eq({tag, "_active"}, 32'(active), 32'd1);
        send_byte(cmd);
        if (kind == c_K_READ) begin
            for (int i = 23; i >= 0; i--) spi_bit(s[i], 1'b0, 1'b0);
        end
        for (int i = 0; i < nbits; i++) spi_bit(1'($urandom), i == nbits - 1, 1'b1);
        repeat (2 * c_HALF) @(negedge clk);
        check_eq({tag, "_idle_active"}, 32'(active), 32'd0);
        check_eq({tag, "_idle_miso"}, 32'(flash_miso), 32'd0);
        for (int j = 0; 8 * j < nbits; j++) begin
            nb  = (nbits - 8 * j > 8) ? 8 : nbits - 8 * j;
            got = 8'd0;
            for (int k = 0; k < nb; k++) got = {got[6:0], rx_q[8 * j + k]};
            exp = exp_byte(kind, s, j) >> (8 - nb);
            check_eq($sformatf("%s_byte%0d", tag, j), 32'(got), 32'(exp));
        end
        if (kind == c_K_READ) begin
            nrd = 1 + (nbits + 7) / 8;          // initial fetch + one per byte begun
            bs_model = bs_model + 32'(nbits / 8); // only whole bytes count
        end else begin
            nrd = 0;
        end
        check_eq({tag, "_rd_count"}, 32'(rd_q.size() - rd_base), 32'(nrd));
        for (int i = 0; i < nrd && rd_base + i < rd_q.size(); i++) begin
            ea = s + 24'(i);
            check_eq($sformatf("%s_rd_addr%0d", tag, i), 32'(rd_q[rd_base + i]),
                     32'(ea[c_AW-1:0]));
        end
        check_eq({tag, "_bytes_served"}, bytes_served, bs_model);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          kind;
        int          nbits;
        logic [7:0]  cmd;
        logic [23:0] a;
        int          rd_base;

        rst        = 1'b1;
        flash_clk  = 1'b0;
        flash_mosi = 1'b0;
        flash_cs   = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("rst_miso",   32'(flash_miso), 32'd0);
        check_eq("rst_rd_en",  32'(mem_rd_en),  32'd0);
        check_eq("rst_addr",   32'(mem_addr),   32'd0);
        check_eq("rst_active", 32'(active),     32'd0);
        check_eq("rst_bytes",  bytes_served,    32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Directed scenarios
        run_txn("rd0", c_K_READ, 8'h03, 24'h000000, 32);
        patch_on = 1'b1;
        run_txn("rdwrap", c_K_READ, 8'h03, 24'hFFFFFE, 24);
        patch_on = 1'b0;
        run_txn("jedec", c_K_ID, 8'h9F, 24'h0, 32);
        run_txn("other", c_K_OTHER, 8'h0B, 24'h0, 32);
        run_txn("partial", c_K_READ, 8'h03, 24'h000010, 13);
        run_txn("rd20", c_K_READ, 8'h03, 24'h000020, 16);

        // Randomized transactions
        for (int t = 0; t < 8; t++) begin
            kind  = int'($urandom_range(0, 2));
            nbits = int'($urandom_range(1, 40));
            a     = 24'($urandom);
            if (kind == c_K_READ)    cmd = 8'h03;
            else if (kind == c_K_ID) cmd = 8'h9F;
            else begin
                cmd = 8'($urandom_range(0, 255));
                if (cmd == 8'h03 || cmd == 8'h9F) cmd = 8'h0B;
            end
            run_txn($sformatf("rnd%0d", t), kind, cmd, a, nbits);
        end

        // Asynchronous reset in the middle of a READ data phase
        rx_q.delete();
        flash_cs = 1'b0;
        repeat (c_HALF) @(negedge clk);
        send_byte(8'h03);
        for (int i = 23; i >= 0; i--) spi_bit(i < 8 ? 1'b1 : 1'b0, 1'b0, 1'b0); // addr 0xFF
        spi_bit(1'b0, 1'b0, 1'b1);
        spi_bit(1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check_eq("pre_rst_miso",   32'(flash_miso), 32'd1);
        check_eq("pre_rst_active", 32'(active),     32'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst_miso",   32'(flash_miso), 32'd0);
        check_eq("async_rst_active", 32'(active),     32'd0);
        check_eq("async_rst_bytes",  bytes_served,    32'd0);
        bs_model = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;                       // CS still low here
        rd_base = rd_q.size();
        send_byte(8'h03);
        repeat (4) @(negedge clk);
        check_eq("cs_low_at_release_active", 32'(active), 32'd0);
        check_eq("cs_low_at_release_rd", 32'(rd_q.size() - rd_base), 32'd0);
        flash_cs = 1'b1;
        repeat (2 * c_HALF) @(negedge clk);
        run_txn("post_rst", c_K_READ, 8'h03, 24'h000000, 16);

        check_eq("no_back_to_back_rd", 32'(consec_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
